// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the dmem_mmio data-memory responder: MMIO offsets,
// controller state encoding and STATUS register layout.
package dmem_pkg;

   // Byte offsets inside the 16-byte MMIO window
   localparam logic [3:0] OFF_RESULT = 4'h0;
   localparam logic [3:0] OFF_CYCLES = 4'h4;
   localparam logic [3:0] OFF_TRACE  = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DONE  = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   localparam int STAT_DONE    = 0;
   localparam int STAT_PASS    = 1;
   localparam int STAT_FAULT   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   function automatic logic [31:0] pack_status(input logic [3:0] cnt,
                                               input logic       ovf,
                                               input logic       flt,
                                               input logic       pss,
                                               input logic       dne);
      logic [31:0] s;
      s                            = '0;
      s[STAT_CNT_LSB+3:STAT_CNT_LSB] = cnt;
      s[STAT_OVF]                  = ovf;
      s[STAT_FAULT]                = flt;
      s[STAT_PASS]                 = pss;
      s[STAT_DONE]                 = dne;
      return s;
   endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Processor load/store port as seen by the data memory.
interface dmem_mmio_if;
   logic        memwrite;
   logic        memread;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output memwrite, memread, dataadr, writedata, input  readdata);
   modport slave  (input  memwrite, memread, dataadr, writedata, output readdata);
endinterface

// File: rtl/dmem_mmio_trace_fifo.sv
// Trace FIFO of store addresses; drops pushes when full unless a pop frees a slot
// on the same edge, and records such drops in a sticky overflow flag.
module trace_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_overflow;
   logic             w_do_push, w_do_pop;

   assign full      = (r_count == FULL_CNT);
   assign empty     = (r_count == '0);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
         if (push && full && !w_do_pop) r_overflow <= 1'b1;
      end
   end

   // NOTE: storage arrays carry no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout     = r_mem[r_rd_ptr];
   assign count    = r_count;
   assign overflow = r_overflow;
endmodule

// File: rtl/dmem_mmio.sv
// Word RAM plus MMIO window (RESULT/CYCLES/TRACE/STATUS) for on-FPGA pass/fail.
// Optional illegal-store checking is enabled by DMEM_MMIO_STORE_CHECK_EN.
module dmem_mmio
   import dmem_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
   parameter logic [31:0] EXPECT      = 32'd7,
   parameter int          TRACE_DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   dmem_mmio_if.slave   bus,
   output logic         done,
   output logic         pass,
   output logic         fault,
   output logic [31:0]  cycles
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(TRACE_DEPTH) + 1;

   logic [31:0] r_ram [DEPTH];
   state_e      r_state, w_state_nxt;
   logic [31:0] r_result, r_cycles;
   logic        r_pass;

   logic          w_in_ram, w_in_mmio, w_illegal, w_store_ok;
   logic          w_ram_we, w_result_we, w_pop;
   logic [3:0]    w_off;
   logic [IW-1:0] w_idx;
   logic [31:0]   w_fifo_dout, w_rdata;
   logic [CW-1:0] w_count;
   logic          w_full, w_empty, w_overflow, w_unused;

   assign w_in_ram  = (bus.dataadr < 32'(4 * DEPTH));
   assign w_in_mmio = (bus.dataadr[31:4] == MMIO_BASE[31:4]);
   assign w_off     = {bus.dataadr[3:2], 2'b00};
   assign w_idx     = bus.dataadr[IW+1:2];

`ifdef DMEM_MMIO_STORE_CHECK_EN
   assign w_illegal = bus.memwrite &&
                      ((bus.dataadr[1:0] != 2'b00) || !(w_in_ram || w_in_mmio));
`else
   assign w_illegal = 1'b0;
`endif

   assign w_store_ok  = bus.memwrite && (r_state == ST_RUN) && !w_illegal && !reset;
   assign w_ram_we    = w_store_ok && w_in_ram;
   assign w_result_we = w_store_ok && !w_in_ram && w_in_mmio && (w_off == OFF_RESULT);
   assign w_pop       = bus.memread && !w_in_ram && w_in_mmio && (w_off == OFF_TRACE);

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_result_we) w_state_nxt = ST_DONE;
`ifdef DMEM_MMIO_STORE_CHECK_EN
            else if (w_illegal) w_state_nxt = ST_FAULT;
`endif
         end
         default: w_state_nxt = r_state;
      endcase
   end

   // Counter holds the value present on the edge that leaves RUN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_RUN;
         r_result <= '0;
         r_pass   <= 1'b0;
         r_cycles <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_result_we) begin
            r_result <= bus.writedata;
            r_pass   <= (bus.writedata == EXPECT);
         end
         if (r_state == ST_RUN && w_state_nxt == ST_RUN && r_cycles != 32'hFFFF_FFFF)
            r_cycles <= r_cycles + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_idx] <= bus.writedata;
   end

   trace_fifo #(.WIDTH(32), .DEPTH(TRACE_DEPTH)) u_trace (
      .clk      (clk),
      .reset    (reset),
      .push     (w_ram_we),
      .pop      (w_pop),
      .din      (bus.dataadr),
      .dout     (w_fifo_dout),
      .count    (w_count),
      .full     (w_full),
      .empty    (w_empty),
      .overflow (w_overflow)
   );

   always_comb begin
      w_rdata = '0;
      if (w_in_ram) begin
         w_rdata = r_ram[w_idx];
      end else if (w_in_mmio) begin
         case (w_off)
            OFF_RESULT: w_rdata = r_result;
            OFF_CYCLES: w_rdata = r_cycles;
            OFF_TRACE:  w_rdata = w_empty ? '0 : w_fifo_dout;
            OFF_STATUS: w_rdata = pack_status(4'(w_count), w_overflow, fault, r_pass, done);
            default:    w_rdata = '0;
         endcase
      end
   end

   assign bus.readdata = w_rdata;
   assign done         = (r_state == ST_DONE);
   assign pass         = r_pass;
   assign cycles       = r_cycles;
`ifdef DMEM_MMIO_STORE_CHECK_EN
   assign fault        = (r_state == ST_FAULT);
`else
   assign fault        = 1'b0;
`endif

   // Byte-lane bits and FIFO full are not needed by the default decode
   assign w_unused = ^{w_full, bus.dataadr[1:0]};
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: vector table plus sequences for counter,
// trace FIFO overflow/pop, misaligned stores and the FIFO full push+pop corner.
module tb_dmem_mmio;
   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        done, pass, fault;
   logic [31:0] cycles;
   int          n_tests = 0;
   int          n_fail  = 0;

   dmem_mmio_if bus();

   dmem_mmio #(.DEPTH(64), .MMIO_BASE(BASE), .EXPECT(32'd7), .TRACE_DEPTH(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .done   (done),
      .pass   (pass),
      .fault  (fault),
      .cycles (cycles)
   );

   logic        f_push, f_pop, f_full, f_empty, f_ovf;
   logic [31:0] f_din, f_dout;
   logic [3:0]  f_count;

   trace_fifo #(.WIDTH(32), .DEPTH(8)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (f_push),
      .pop      (f_pop),
      .din      (f_din),
      .dout     (f_dout),
      .count    (f_count),
      .full     (f_full),
      .empty    (f_empty),
      .overflow (f_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic        re;
      logic [31:0] adr;
      logic [31:0] wd;
      logic        chk;
      logic [31:0] rd;
      logic [2:0]  flg;   // {done, pass, fault} after the edge
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic we, input logic re,
                               input logic [31:0] adr, input logic [31:0] wd,
                               input logic chk, input logic [31:0] rd,
                               input logic [2:0] flg);
      vec_t v;
      v.rst = rst; v.we = we; v.re = re; v.adr = adr; v.wd = wd;
      v.chk = chk; v.rd = rd; v.flg = flg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic re,
                        input logic [31:0] adr, input logic [31:0] wd);
      @(negedge clk);
      bus.memwrite  = we;
      bus.memread   = re;
      bus.dataadr   = adr;
      bus.writedata = wd;
   endtask

   // Leaves the bench at the negedge of cycle 1 after release
   task automatic do_reset(input int n);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bus.memwrite = 1'b0; bus.memread = 1'b0; bus.dataadr = '0; bus.writedata = '0;
      f_push = 1'b0; f_pop = 1'b0; f_din = '0;

      // Pass scenario, then suppression in DONE
      vecs.push_back(mk(1, 0, 0, BASE,      0,  1, 32'h0,  3'b000));
      vecs.push_back(mk(0, 0, 0, BASE+12,   0,  1, 32'h0,  3'b000));
      vecs.push_back(mk(0, 1, 0, 32'd80,    3,  0, 32'h0,  3'b000));
      vecs.push_back(mk(0, 0, 0, 32'd80,    0,  1, 32'd3,  3'b000));
      vecs.push_back(mk(0, 0, 0, BASE+12,   0,  1, 32'h10, 3'b000));
      vecs.push_back(mk(0, 1, 0, BASE,      7,  0, 32'h0,  3'b110));
      vecs.push_back(mk(0, 0, 0, 32'd80,    0,  1, 32'd3,  3'b110));
      vecs.push_back(mk(0, 0, 0, BASE,      0,  1, 32'd7,  3'b110));
      vecs.push_back(mk(0, 0, 0, BASE+12,   0,  1, 32'h13, 3'b110));
      vecs.push_back(mk(0, 0, 0, 32'h1000,  0,  1, 32'h0,  3'b110));
      vecs.push_back(mk(0, 1, 0, 32'd80,    9,  0, 32'h0,  3'b110));
      vecs.push_back(mk(0, 0, 0, 32'd80,    0,  1, 32'd3,  3'b110));
      vecs.push_back(mk(0, 1, 0, BASE,      5,  0, 32'h0,  3'b110));
      vecs.push_back(mk(0, 0, 0, BASE,      0,  1, 32'd7,  3'b110));
      vecs.push_back(mk(0, 0, 0, BASE+12,   0,  1, 32'h13, 3'b110));
      // Fail scenario: wrong RESULT, later store suppressed
      vecs.push_back(mk(1, 1, 0, 32'd4,  32'h44, 0, 32'h0,  3'b000));
      vecs.push_back(mk(0, 1, 0, BASE,      5,  0, 32'h0,  3'b100));
      vecs.push_back(mk(0, 1, 0, 32'd4,     9,  0, 32'h0,  3'b100));
      vecs.push_back(mk(0, 0, 0, 32'd4,     0,  1, 32'h44, 3'b100));
      vecs.push_back(mk(0, 0, 0, BASE,      0,  1, 32'd5,  3'b100));
      vecs.push_back(mk(0, 0, 0, BASE+12,   0,  1, 32'h11, 3'b100));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset(1);
         drive(vecs[i].we, vecs[i].re, vecs[i].adr, vecs[i].wd);
         #1;
         if (vecs[i].chk) check($sformatf("v%0d_rd", i), bus.readdata, vecs[i].rd);
         @(posedge clk); #1;
         check($sformatf("v%0d_flags", i), {29'b0, done, pass, fault}, {29'b0, vecs[i].flg});
      end

      // Cycle counter: reset held 3 cycles, RESULT written in cycle 20
      do_reset(3);
      bus.dataadr = BASE + 4;
      #1;
      check("cyc_start", cycles, 32'd0);
      check("cyc_start_rd", bus.readdata, 32'd0);
      repeat (19) @(negedge clk);
      #1;
      check("cyc_20", cycles, 32'd19);
      bus.memwrite = 1'b1; bus.dataadr = BASE; bus.writedata = 32'd7;
      @(posedge clk); #1;
      check("cyc_done", {31'b0, done}, 32'd1);
      drive(0, 0, BASE + 4, 0);
      repeat (3) @(negedge clk);
      #1;
      check("cyc_frozen", cycles, 32'd19);
      check("cyc_frozen_rd", bus.readdata, 32'd19);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("cyc_rst", cycles, 32'd0);
      check("cyc_rst_done", {31'b0, done}, 32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      check("cyc_run", cycles, 32'd1);
      // Reset wins over a RESULT store in flight
      drive(1, 0, BASE, 7);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_inflight_done", {31'b0, done}, 32'd0);
      check("rst_inflight_cyc", cycles, 32'd0);
      @(negedge clk); reset = 1'b0; bus.memwrite = 1'b0;

      // Trace overflow and drain
      do_reset(1);
      for (int i = 0; i < 10; i++) drive(1, 0, 32'(4 * i), 32'(i));
      drive(0, 0, BASE + 12, 0);
      #1;
      check("ovf_status", bus.readdata, 32'h88);
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, BASE + 8, 0);
         #1;
         check($sformatf("trace_%0d", i), bus.readdata, 32'(4 * i));
      end
      drive(0, 1, BASE + 8, 0);
      #1;
      check("trace_empty", bus.readdata, 32'd0);
      drive(0, 0, BASE + 12, 0);
      #1;
      check("drained_status", bus.readdata, 32'h08);
      drive(0, 0, 32'd36, 0);
      #1;
      check("ram_36", bus.readdata, 32'd9);

      // Misaligned store to 82
      do_reset(1);
      drive(1, 0, 32'd82, 32'hAB);
      @(posedge clk); #1;
`ifdef DMEM_MMIO_STORE_CHECK_EN
      check("mis_fault", {31'b0, fault}, 32'd1);
      drive(0, 0, BASE + 12, 0);
      #1;
      check("mis_status", bus.readdata, 32'h04);
`else
      check("mis_fault", {31'b0, fault}, 32'd0);
      drive(1, 0, 32'h2000, 32'h55);
      drive(0, 0, 32'd80, 0);
      #1;
      check("mis_word20", bus.readdata, 32'hAB);
      drive(0, 0, BASE + 12, 0);
      #1;
      check("mis_status", bus.readdata, 32'h10);
`endif
      drive(0, 0, 0, 0);

      // FIFO full with simultaneous push and pop, then drop, then empty pop
      do_reset(1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); f_push = 1'b1; f_din = 32'(100 + i);
      end
      @(negedge clk); f_push = 1'b0;
      #1;
      check("ff_full_cnt", {28'b0, f_count}, 32'd8);
      check("ff_head0", f_dout, 32'd100);
      @(negedge clk); f_push = 1'b1; f_pop = 1'b1; f_din = 32'd200;
      @(posedge clk); #1;
      check("ff_pp_cnt", {28'b0, f_count}, 32'd8);
      check("ff_pp_ovf", {31'b0, f_ovf}, 32'd0);
      check("ff_pp_head", f_dout, 32'd101);
      @(negedge clk); f_pop = 1'b0; f_din = 32'd300;
      @(posedge clk); #1;
      check("ff_drop_ovf", {31'b0, f_ovf}, 32'd1);
      check("ff_drop_cnt", {28'b0, f_count}, 32'd8);
      @(negedge clk); f_push = 1'b0; f_pop = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("ff_tail", f_dout, 32'd200);
      repeat (2) @(posedge clk);
      #1;
      check("ff_empty_cnt", {28'b0, f_count}, 32'd0);
      check("ff_empty_flag", {31'b0, f_empty}, 32'd1);
      @(negedge clk); f_pop = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
